mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle successor to the single-cycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, driving the shared-memory multicycle datapath.
- Supports LW, SW, R-type (ADD/SUB/AND/OR/SLT), BEQ, BNE, ADDI, ORI, LUI and J.
- Adds an optional memory ready handshake with a timeout, and illegal-instruction detection.

Parameters:
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
- MAX_WAIT, 16, cycles allowed in one memory state before timeout; 0 disables the timeout.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- op  in  6  instruction[31:26], taken from the instruction register.
- funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write enable.
- irwrite  out  1  instruction register load.
- regdst  out  1  write register select: 1 = rd, 0 = rt.
- memtoreg  out  1  writeback select: 1 = data register, 0 = ALUOut.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A select: 0 = PC, 1 = A.
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2.
- pcsrc  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- pcen  out  1  PC write enable.
- alucontrol  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- immtype  out  2  immediate extension: 00 sign, 01 zero, 10 upper (imm<<16).
- illegal  out  1  one-cycle pulse on an unsupported op or funct.
- mem_timeout  out  1  one-cycle pulse when a memory wait expires.
- state  out  4  current state code, for debug.

Behaviour:
- Outputs are decoded from the current state only, except pcen in BRANCH and the ready-gated strobes.
- Unlisted outputs in any state are 0; alucontrol defaults to 0010.
- Reset: while reset_n=0 at a clock edge, state <= FETCH (code 0) and the wait counter <= 0. Reset applied mid-instruction abandons the instruction; no write strobe is asserted in the cycle after reset.
- FETCH(0): alusrcb=01, add. irwrite and pcen are asserted only in the cycle mem_ready=1; that cycle moves to DECODE, otherwise stay.
- DECODE(1): alusrcb=11, add. Next state:
  - LW/SW -> MEMADR(2)
  - R-type with supported funct -> EXEC(6)
  - BEQ(000100)/BNE(000101) -> BRANCH(8)
  - ADDI/ORI/LUI -> IMMEX(9)
  - J -> JUMP(11)
  - anything else -> ILLEGAL(12)
- MEMADR(2): alusrca=1, alusrcb=10, immtype=00. Next: LW -> MEMRD(3), SW -> MEMWR(5).
- MEMRD(3): iord=1. Leaves to MEMWB(4) on mem_ready.
- MEMWB(4): memtoreg=1, regwrite=1. Next: FETCH.
- MEMWR(5): iord=1, memwrite=1 held until mem_ready. On mem_ready -> FETCH.
- EXEC(6): alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt). Next: ALUWB(7).
- ALUWB(7): regdst=1, regwrite=1. Next: FETCH.
- BRANCH(8): alusrca=1, sub, pcsrc=01. pcen = zero for BEQ, ~zero for BNE. Next: FETCH.
- IMMEX(9): alusrca=1, alusrcb=10.
  - ADDI: add, immtype 00.
  - ORI: or, immtype 01.
  - LUI: or, immtype 10.
  - Next: IMMWB(10).
- IMMWB(10): regwrite=1, regdst=0; immtype and alucontrol held as in IMMEX. Next: FETCH.
- JUMP(11): pcsrc=10, pcen=1. Next: FETCH.
- ILLEGAL(12): illegal=1 for one cycle, no writes; the instruction is skipped because the PC already advanced. Next: FETCH.
- Wait counter:
  - Counts cycles spent in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on any state change.
  - If it reaches MAX_WAIT-1 while mem_ready=0: mem_timeout=1 for that cycle, state -> FETCH, counter cleared, and no write strobe is asserted that cycle.
  - A timeout in FETCH re-fetches.
- Simultaneous mem_ready=1 and timeout: ready wins and the access completes.
- With MEM_HANDSHAKE=0 every memory state lasts exactly 1 cycle and mem_timeout never asserts.
- Instruction latencies with ready always high: LW 5, SW 4, R-type 4, ADDI/ORI/LUI 4, BEQ/BNE 3, J 3, illegal 3 cycles.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1, op=100011 -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; irwrite=1 only in cycle 0.
- R-type op=0, funct=101010 -> EXEC with alucontrol=0111, then ALUWB with regdst=1, regwrite=1. funct=111111 -> ILLEGAL with one illegal pulse, no regwrite.
- BNE op=000101: zero=1 -> pcen=0 in state 8; zero=0 -> pcen=1 with pcsrc=01. BEQ gives the opposite results.
- LUI op=001111 -> IMMEX shows alucontrol=0001, immtype=10; IMMWB has regwrite=1 and immtype still 10.
- SW with mem_ready low 3 cycles -> memwrite held high for 4 cycles in state 5, then FETCH. With MAX_WAIT=4 and mem_ready never high -> mem_timeout pulses in the 4th wait cycle, memwrite=0 in that cycle, next state FETCH.
- reset_n dropped while in MEMWR -> next state FETCH, memwrite=0 in the following cycle, counter=0.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with an optional memory ready handshake, wait timeout and illegal-instruction detection.
module mc_controller #(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned MAX_WAIT      = 16,
  parameter int unsigned CNT_W         = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [3:0] alucontrol,
  output logic [1:0] immtype,
  output logic       illegal,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] IMM_SIGN  = 2'b00;
  localparam logic [1:0] IMM_ZERO  = 2'b01;
  localparam logic [1:0] IMM_UPPER = 2'b10;

  state_t           cur_state;
  logic [CNT_W-1:0] wait_cnt;
  logic             ready;
  logic             mem_state;
  logic             timeout;
  logic             funct_ok;
  logic [3:0]       funct_alu;
  logic [3:0]       imm_alu;
  logic [1:0]       imm_ext;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state = cur_state;

  // A stalled memory state expires on its MAX_WAIT-th cycle; a ready access always wins.
  always_comb begin
    mem_state = (cur_state == S_FETCH) || (cur_state == S_MEMRD) || (cur_state == S_MEMWR);
    timeout   = mem_state && !ready && (MAX_WAIT != 0) &&
                (wait_cnt == CNT_W'(MAX_WAIT - 1));
  end

  // R-type function decode
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Immediate-class ALU op and extension; shared by IMMEX and IMMWB
  always_comb begin
    imm_alu = ALU_ADD;
    imm_ext = IMM_SIGN;
    if (op == OP_ORI) begin
      imm_alu = ALU_OR;
      imm_ext = IMM_ZERO;
    end else if (op == OP_LUI) begin
      imm_alu = ALU_OR;
      imm_ext = IMM_UPPER;
    end
  end

  // State register, next-state logic and wait counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
    end else if (timeout) begin
      cur_state <= S_FETCH;
      wait_cnt  <= '0;
    end else begin
      // A stalled memory state keeps its state, so counting here never spans a state change.
      wait_cnt <= (mem_state && !ready) ? wait_cnt + CNT_W'(1) : '0;
      case (cur_state)
        S_FETCH:  if (ready) cur_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW:            cur_state <= S_MEMADR;
            OP_RTYPE:                cur_state <= funct_ok ? S_EXEC : S_ILLEGAL;
            OP_BEQ, OP_BNE:          cur_state <= S_BRANCH;
            OP_ADDI, OP_ORI, OP_LUI: cur_state <= S_IMMEX;
            OP_J:                    cur_state <= S_JUMP;
            default:                 cur_state <= S_ILLEGAL;
          endcase
        end
        S_MEMADR: begin
          if (op == OP_LW)      cur_state <= S_MEMRD;
          else if (op == OP_SW) cur_state <= S_MEMWR;
          else                  cur_state <= S_FETCH;
        end
        S_MEMRD:  if (ready) cur_state <= S_MEMWB;
        S_MEMWR:  if (ready) cur_state <= S_FETCH;
        S_EXEC:   cur_state <= S_ALUWB;
        S_IMMEX:  cur_state <= S_IMMWB;
        default:  cur_state <= S_FETCH;
      endcase
    end
  end

  // Output decode from the current state; unlisted outputs stay at their defaults
  always_comb begin
    iord        = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    pcen        = 1'b0;
    alucontrol  = ALU_ADD;
    immtype     = IMM_SIGN;
    illegal     = 1'b0;
    mem_timeout = timeout;
    case (cur_state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = ready;
        pcen    = ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = !timeout;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = (op == OP_BEQ) ? zero : !zero;
      end
      S_IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = imm_alu;
        immtype    = imm_ext;
      end
      S_IMMWB: begin
        regwrite   = 1'b1;
        alucontrol = imm_alu;
        immtype    = imm_ext;
      end
      S_JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed literal checks, then a randomized run compared every
// cycle against an instruction-level model (per-opcode state route plus a wait count).
module tb_mc_controller;

  localparam int unsigned MAXW = 4;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2a;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [3:0] alucontrol;
    logic [1:0] immtype;
    logic       illegal;
    logic       mem_timeout;
    logic [3:0] state;
  } ctl_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = OP_LW;
  logic [5:0] funct = F_ADD;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
  logic       illegal, mem_timeout;
  logic [1:0] alusrcb, pcsrc, immtype;
  logic [3:0] alucontrol, state;
  ctl_t       got;

  always #5 clk = ~clk;

  mc_controller #(.MEM_HANDSHAKE(1'b1), .MAX_WAIT(MAXW), .CNT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol),
    .immtype(immtype), .illegal(illegal), .mem_timeout(mem_timeout), .state(state)
  );

  assign got = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
                pcsrc, pcen, alucontrol, immtype, illegal, mem_timeout, state};

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  int plan[$];
  int wcnt = 0;
  bit mvalid = 1'b0;
  int cur_s;
  int rt;

  function automatic bit is_mem(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  function automatic bit funct_ok(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT);
  endfunction

  function automatic logic [3:0] alu_of(input logic [5:0] f);
    case (f)
      F_SUB:   return 4'b0110;
      F_AND:   return 4'b0000;
      F_OR:    return 4'b0001;
      F_SLT:   return 4'b0111;
      default: return 4'b0010;
    endcase
  endfunction

  // States visited after FETCH, one hex digit each, in order
  function automatic int route(input logic [5:0] o, input logic [5:0] f);
    case (o)
      OP_LW:                   return 32'h1234;
      OP_SW:                   return 32'h125;
      OP_R:                    return funct_ok(f) ? 32'h167 : 32'h1C;
      OP_BEQ, OP_BNE:          return 32'h18;
      OP_ADDI, OP_ORI, OP_LUI: return 32'h19A;
      OP_J:                    return 32'h1B;
      default:                 return 32'h1C;
    endcase
  endfunction

  function automatic ctl_t expect_ctl(input int s, input logic [5:0] o, input logic [5:0] f,
                                      input logic z, input logic rdy, input int w);
    ctl_t e;
    logic tmo;
    e = '0;
    e.alucontrol = 4'b0010;
    e.state = 4'(s);
    tmo = is_mem(s) && !rdy && (w == int'(MAXW) - 1);
    case (s)
      0: begin e.alusrcb = 2'b01; e.irwrite = rdy; e.pcen = rdy; end
      1: e.alusrcb = 2'b11;
      2: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      3: e.iord = 1'b1;
      4: begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      5: begin e.iord = 1'b1; e.memwrite = !tmo; end
      6: begin e.alusrca = 1'b1; e.alucontrol = alu_of(f); end
      7: begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      8: begin
        e.alusrca = 1'b1; e.alucontrol = 4'b0110; e.pcsrc = 2'b01;
        e.pcen = (o == OP_BEQ) ? z : !z;
      end
      9, 10: begin
        if (s == 9) begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
        else e.regwrite = 1'b1;
        if (o == OP_ORI) begin e.alucontrol = 4'b0001; e.immtype = 2'b01; end
        else if (o == OP_LUI) begin e.alucontrol = 4'b0001; e.immtype = 2'b10; end
      end
      11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      12: e.illegal = 1'b1;
      default: ;
    endcase
    e.mem_timeout = tmo;
    return e;
  endfunction

  // Advance the model on each rising edge from the inputs held across it
  always @(posedge clk) begin
    if (!reset_n) begin
      plan.delete();
      plan.push_back(0);
      wcnt   = 0;
      mvalid = 1'b1;
    end else if (mvalid) begin
      cur_s = plan[0];
      if (is_mem(cur_s) && !mem_ready) begin
        if (wcnt == int'(MAXW) - 1) begin
          plan.delete();
          plan.push_back(0);
          wcnt = 0;
        end else begin
          wcnt = wcnt + 1;
        end
      end else begin
        wcnt = 0;
        void'(plan.pop_front());
        if (cur_s == 0) begin
          rt = route(op, funct);
          for (int k = 7; k >= 0; k--)
            if (((rt >> (4 * k)) & 15) != 0) plan.push_back((rt >> (4 * k)) & 15);
        end else if (plan.size() == 0) begin
          plan.push_back(0);
        end
      end
    end
  end

  ctl_t exp_c;
  always @(negedge clk) begin
    if (mvalid) begin
      exp_c = expect_ctl(plan[0], op, funct, zero, mem_ready, wcnt);
      n_checks++;
      if (got !== exp_c) begin
        n_fail++;
        $display("FAIL cycle_ctl t=%0t model_state=%0d got=%h want=%h",
                 $time, plan[0], got, exp_c);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic rn, input logic rdy, input logic [5:0] o,
                      input logic [5:0] f, input logic z);
    @(posedge clk);
    #1;
    reset_n = rn; mem_ready = rdy; op = o; funct = f; zero = z;
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] g, input logic [7:0] w);
    n_checks++;
    if (g !== w) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, g, w);
    end
  endtask

  task automatic st(input logic rn, input logic rdy, input logic [5:0] o, input logic [5:0] f,
                    input logic z, input int want);
    step(rn, rdy, o, f, z);
    chk("state_seq", 8'(state), 8'(want));
  endtask

  int mode;
  int k;

  initial begin
    // LW from reset
    step(1'b0, 1'b1, OP_LW, F_ADD, 1'b0);
    chk("reset_state", 8'(state), 8'd0);
    st(1, 1, OP_LW, F_ADD, 0, 0);
    chk("lw_irwrite_c0", 8'({irwrite, regwrite}), 8'h2);
    st(1, 1, OP_LW, F_ADD, 0, 1);
    chk("lw_irwrite_c1", 8'(irwrite), 8'd0);
    st(1, 1, OP_LW, F_ADD, 0, 2);
    st(1, 1, OP_LW, F_ADD, 0, 3);
    chk("lw_iord", 8'({iord, regwrite}), 8'h2);
    st(1, 1, OP_LW, F_ADD, 0, 4);
    chk("lw_writeback", 8'({memtoreg, regwrite}), 8'h3);
    // R-type SLT, then unsupported funct
    st(1, 1, OP_R, F_SLT, 0, 0);
    chk("lw_done_regwrite", 8'({memtoreg, regwrite}), 8'h0);
    st(1, 1, OP_R, F_SLT, 0, 1);
    st(1, 1, OP_R, F_SLT, 0, 6);
    chk("slt_alucontrol", 8'(alucontrol), 8'h07);
    st(1, 1, OP_R, F_SLT, 0, 7);
    chk("slt_writeback", 8'({regdst, regwrite}), 8'h3);
    st(1, 1, OP_R, 6'h3f, 0, 0);
    st(1, 1, OP_R, 6'h3f, 0, 1);
    st(1, 1, OP_R, 6'h3f, 0, 12);
    chk("bad_funct_illegal", 8'({illegal, regwrite}), 8'h2);
    // BNE / BEQ with both zero values
    st(1, 1, OP_BNE, F_ADD, 1, 0);
    st(1, 1, OP_BNE, F_ADD, 1, 1);
    st(1, 1, OP_BNE, F_ADD, 1, 8);
    chk("bne_zero1_pcen", 8'(pcen), 8'd0);
    st(1, 1, OP_BNE, F_ADD, 0, 0);
    st(1, 1, OP_BNE, F_ADD, 0, 1);
    st(1, 1, OP_BNE, F_ADD, 0, 8);
    chk("bne_zero0_pcen_pcsrc", 8'({pcen, pcsrc}), 8'h5);
    st(1, 1, OP_BEQ, F_ADD, 1, 0);
    st(1, 1, OP_BEQ, F_ADD, 1, 1);
    st(1, 1, OP_BEQ, F_ADD, 1, 8);
    chk("beq_zero1_pcen", 8'(pcen), 8'd1);
    st(1, 1, OP_BEQ, F_ADD, 0, 0);
    st(1, 1, OP_BEQ, F_ADD, 0, 1);
    st(1, 1, OP_BEQ, F_ADD, 0, 8);
    chk("beq_zero0_pcen", 8'(pcen), 8'd0);
    // LUI
    st(1, 1, OP_LUI, F_ADD, 0, 0);
    st(1, 1, OP_LUI, F_ADD, 0, 1);
    st(1, 1, OP_LUI, F_ADD, 0, 9);
    chk("lui_immex", 8'({alucontrol, immtype}), 8'h06);
    st(1, 1, OP_LUI, F_ADD, 0, 10);
    chk("lui_immwb", 8'({regwrite, immtype}), 8'h06);
    // SW with ready low for 3 cycles: ready on the 4th wins over the timeout
    st(1, 1, OP_SW, F_ADD, 0, 0);
    st(1, 1, OP_SW, F_ADD, 0, 1);
    st(1, 0, OP_SW, F_ADD, 0, 2);
    for (int i = 0; i < 4; i++) begin
      st(1, (i == 3), OP_SW, F_ADD, 0, 5);
      chk("sw_wait_memwrite", 8'({mem_timeout, memwrite}), 8'h1);
    end
    // SW never ready: timeout on the 4th wait cycle
    st(1, 1, OP_SW, F_ADD, 0, 0);
    st(1, 1, OP_SW, F_ADD, 0, 1);
    st(1, 0, OP_SW, F_ADD, 0, 2);
    for (int i = 0; i < 4; i++) begin
      st(1, 0, OP_SW, F_ADD, 0, 5);
      chk("sw_timeout", 8'({mem_timeout, memwrite}), (i == 3) ? 8'h2 : 8'h1);
    end
    // Reset dropped in MEMWR
    st(1, 1, OP_SW, F_ADD, 0, 0);
    st(1, 1, OP_SW, F_ADD, 0, 1);
    st(1, 0, OP_SW, F_ADD, 0, 2);
    st(1, 0, OP_SW, F_ADD, 0, 5);
    st(0, 0, OP_SW, F_ADD, 0, 5);
    st(1, 0, OP_SW, F_ADD, 0, 0);
    chk("reset_in_memwr_memwrite", 8'(memwrite), 8'd0);
    for (int i = 0; i < 3; i++) begin
      st(1, 0, OP_SW, F_ADD, 0, 0);
      chk("fetch_timeout_after_reset", 8'(mem_timeout), (i == 2) ? 8'd1 : 8'd0);
    end
    st(1, 1, OP_ADDI, F_ADD, 0, 0);
    chk("refetch_irwrite", 8'(irwrite), 8'd1);

    // Randomized run; opcodes only change while the FSM sits in FETCH
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 24 == 0) mode = int'($urandom_range(0, 2));
      @(posedge clk);
      #1;
      if (plan[0] == 0) begin
        k = int'($urandom_range(0, 9));
        case (k)
          0: op = OP_LW;   1: op = OP_SW;   2: op = OP_R;    3: op = OP_BEQ;
          4: op = OP_BNE;  5: op = OP_ADDI; 6: op = OP_ORI;  7: op = OP_LUI;
          8: op = OP_J;    default: op = 6'($urandom);
        endcase
        k = int'($urandom_range(0, 5));
        case (k)
          0: funct = F_ADD; 1: funct = F_SUB; 2: funct = F_AND;
          3: funct = F_OR;  4: funct = F_SLT; default: funct = 6'($urandom);
        endcase
      end
      case (mode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = ($urandom_range(0, 9) < 7);
        default: mem_ready = ($urandom_range(0, 9) < 2);
      endcase
      zero    = 1'($urandom_range(0, 1));
      reset_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
